// File: rtl/msg_arbiter.sv
// Round-robin message arbiter: merges NUM_REQ framed beat streams onto one output bus without interleaving.
// Optional stall watchdog with abort beat is compiled in by defining MSG_ARB_WATCHDOG_EN.
module msg_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int WDOG_LIMIT = 256
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ-1:0]            Req_Start,
  input  logic [NUM_REQ-1:0]            Req_End,
  input  logic [NUM_REQ*4-1:0]          Req_Mod,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ready,
  input  logic                          OutBus_Ready,
  output logic                          OutBus_Valid,
  output logic                          OutBus_Sart_Msg,
  output logic                          OutBus_End_Msg,
  output logic [3:0]                    OutBus_Mod,
  output logic [DATA_WIDTH-1:0]         OutBus_Data,
  output logic [2:0]                    Grant_Id,
  output logic                          Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY
`ifdef MSG_ARB_WATCHDOG_EN
    , S_ABORT
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic       first_q, first_d;
  logic       err_q, err_d;

`ifdef MSG_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  // Granted requester's lanes.
  logic                  g_valid, g_start, g_end;
  logic [3:0]            g_mod;
  logic [DATA_WIDTH-1:0] g_data;

  always_comb begin
    g_valid = 1'b0;
    g_start = 1'b0;
    g_end   = 1'b0;
    g_mod   = '0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid = Req_Valid[i];
        g_start = Req_Start[i];
        g_end   = Req_End[i];
        g_mod   = Req_Mod[i*4 +: 4];
        g_data  = Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pick: lowest candidate above last_grant, else wrap to the lowest candidate overall.
  logic [NUM_REQ-1:0] stray, cand;
  logic               hi_found, arb_any;
  logic [2:0]         hi_sel, lo_sel, arb_sel;

  always_comb begin
    stray    = Req_Valid & ~Req_Start;
    cand     = Req_Valid & Req_Start;
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) lo_sel = 3'(i);
      if (cand[i] && (3'(i) > last_grant_q)) begin
        hi_found = 1'b1;
        hi_sel   = 3'(i);
      end
    end
    arb_sel = hi_found ? hi_sel : lo_sel;
    arb_any = |cand;
  end

  logic [NUM_REQ-1:0]    ready;
  logic                  out_valid, out_sart, out_end, mod_bad, xfer;
  logic [3:0]            out_mod;
  logic [DATA_WIDTH-1:0] out_data;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    err_d        = 1'b0;
    ready        = '0;
    out_valid    = 1'b0;
    out_sart     = 1'b0;
    out_end      = 1'b0;
    out_mod      = '0;
    out_data     = '0;
    mod_bad      = 1'b0;
    xfer         = 1'b0;
`ifdef MSG_ARB_WATCHDOG_EN
    wdog_d       = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready = stray;
        err_d = |stray;
        if (arb_any) begin
          grant_d = arb_sel;
          first_d = 1'b1;
          state_d = S_BUSY;
`ifdef MSG_ARB_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end
      end
      S_BUSY: begin
        mod_bad   = g_end && ((g_mod == 4'd0) || (g_mod > 4'd8));
        out_valid = g_valid;
        out_sart  = g_start & first_q;
        out_end   = g_end;
        out_mod   = mod_bad ? 4'd8 : g_mod;
        out_data  = g_data;
        for (int i = 0; i < NUM_REQ; i++) ready[i] = (grant_q == 3'(i)) & OutBus_Ready;
        xfer = g_valid & OutBus_Ready;
        if (xfer) begin
          first_d = 1'b0;
          err_d   = (g_start & ~first_q) | mod_bad;
`ifdef MSG_ARB_WATCHDOG_EN
          wdog_d  = '0;
`endif
          if (g_end) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end
`ifdef MSG_ARB_WATCHDOG_EN
        else if (!g_valid) begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_d == WDOG_W'(WDOG_LIMIT)) state_d = S_ABORT;
        end
`endif
      end
`ifdef MSG_ARB_WATCHDOG_EN
      S_ABORT: begin
        // Synthetic terminator closes the stalled message downstream.
        out_valid = 1'b1;
        out_end   = 1'b1;
        if (OutBus_Ready) begin
          err_d        = 1'b1;
          last_grant_d = grant_q;
          wdog_d       = '0;
          state_d      = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
      first_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef MSG_ARB_WATCHDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      err_q        <= err_d;
`ifdef MSG_ARB_WATCHDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  // IDLE drains stray beats, so ready must also be gated while reset is held.
  assign Req_Ready       = Rst ? ready : '0;
  assign OutBus_Valid    = out_valid;
  assign OutBus_Sart_Msg = out_sart;
  assign OutBus_End_Msg  = out_end;
  assign OutBus_Mod      = out_mod;
  assign OutBus_Data     = out_data;
  assign Grant_Id        = grant_q;
  assign Err             = err_q;

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed bench for msg_arbiter: queue-driven requesters, output monitor, hand-computed expectations.
// Watchdog scenario is compiled only when MSG_ARB_WATCHDOG_EN is defined.
module tb_msg_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  typedef struct packed {
    logic          start;
    logic          endm;
    logic [3:0]    mod;
    logic [DW-1:0] data;
  } beat_t;

  logic             Clk, Rst;
  logic [NR-1:0]    Req_Valid, Req_Start, Req_End, Req_Ready;
  logic [NR*4-1:0]  Req_Mod;
  logic [NR*DW-1:0] Req_Data;
  logic             OutBus_Ready, OutBus_Valid, OutBus_Sart_Msg, OutBus_End_Msg, Err;
  logic [3:0]       OutBus_Mod;
  logic [DW-1:0]    OutBus_Data;
  logic [2:0]       Grant_Id;

  msg_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .WDOG_LIMIT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid(Req_Valid), .Req_Start(Req_Start), .Req_End(Req_End),
    .Req_Mod(Req_Mod), .Req_Data(Req_Data), .Req_Ready(Req_Ready),
    .OutBus_Ready(OutBus_Ready), .OutBus_Valid(OutBus_Valid),
    .OutBus_Sart_Msg(OutBus_Sart_Msg), .OutBus_End_Msg(OutBus_End_Msg),
    .OutBus_Mod(OutBus_Mod), .OutBus_Data(OutBus_Data),
    .Grant_Id(Grant_Id), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  beat_t      rq [NR][$];
  beat_t      out_log [$];
  logic [2:0] gid_log [$];
  int         cyc_log [$];
  logic [NR-1:0] rr_log [$];
  int  cyc, err_count;
  int  n_tests = 0, n_fail = 0;
  bit  use_pat = 1'b0;
  bit  ready_pat [0:31];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input bit s, input bit e, input logic [3:0] m, input logic [DW-1:0] d);
    beat_t b;
    b.start = s; b.endm = e; b.mod = m; b.data = d;
    rq[r].push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() != 0) begin
        Req_Valid[i]        = 1'b1;
        Req_Start[i]        = rq[i][0].start;
        Req_End[i]          = rq[i][0].endm;
        Req_Mod[i*4 +: 4]   = rq[i][0].mod;
        Req_Data[i*DW +: DW] = rq[i][0].data;
      end else begin
        Req_Valid[i]        = 1'b0;
        Req_Start[i]        = 1'b0;
        Req_End[i]          = 1'b0;
        Req_Mod[i*4 +: 4]   = '0;
        Req_Data[i*DW +: DW] = '0;
      end
    end
    OutBus_Ready = (use_pat && cyc < 32) ? ready_pat[cyc] : 1'b1;
  endtask

  // Monitor on the falling edge, then advance the sources after the rising edge.
  task automatic tick();
    logic [NR-1:0] pop;
    beat_t b;
    @(negedge Clk);
    rr_log.push_back(Req_Ready);
    if (OutBus_Valid && OutBus_Ready) begin
      b.start = OutBus_Sart_Msg; b.endm = OutBus_End_Msg; b.mod = OutBus_Mod; b.data = OutBus_Data;
      out_log.push_back(b);
      gid_log.push_back(Grant_Id);
      cyc_log.push_back(cyc);
    end
    if (Err) err_count++;
    pop = Req_Valid & Req_Ready;
    @(posedge Clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (pop[i]) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic begin_test();
    out_log.delete(); gid_log.delete(); cyc_log.delete(); rr_log.delete();
    cyc = 1;
    err_count = 0;
  endtask

  task automatic reset_dut();
    Rst = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive();
    run(2);
    Rst = 1'b1;
  endtask

  task automatic exp_beat(input string t, input int k, input int c, input int g,
                          input bit s, input bit e, input logic [3:0] m, input logic [DW-1:0] d);
    if (k < out_log.size()) begin
      check($sformatf("%s_b%0d_cyc", t, k), 64'(cyc_log[k]), 64'(c));
      check($sformatf("%s_b%0d_gid", t, k), 64'(gid_log[k]), 64'(g));
      check($sformatf("%s_b%0d_flags", t, k),
            64'({out_log[k].start, out_log[k].endm, out_log[k].mod}), 64'({s, e, m}));
      check($sformatf("%s_b%0d_data", t, k), out_log[k].data, d);
    end else begin
      check($sformatf("%s_b%0d_missing", t, k), 64'(out_log.size()), 64'(k + 1));
    end
  endtask

  initial begin
    logic [DW-1:0] dv [6];
    cyc = 0;
    err_count = 0;
    Rst = 1'b0;
    push(3, 1'b0, 1'b1, 4'd8, 64'h33);
    push(0, 1'b1, 1'b0, 4'd0, 64'h01);
    drive();

    // Reset state with requesters active
    @(negedge Clk);
    check("rst_ready", 64'(Req_Ready), 64'h0);
    check("rst_valid", 64'(OutBus_Valid), 64'h0);
    check("rst_gid", 64'(Grant_Id), 64'h0);
    check("rst_err", 64'(Err), 64'h0);
    check("rst_data", OutBus_Data, 64'h0);
    reset_dut();

    // Two concurrent 3-beat messages: 0 first, then 2, never interleaved
    begin_test();
    push(0, 1'b1, 1'b0, 4'd0, 64'hA0); push(0, 1'b0, 1'b0, 4'd0, 64'hA1); push(0, 1'b0, 1'b1, 4'd8, 64'hA2);
    push(2, 1'b1, 1'b0, 4'd0, 64'hC0); push(2, 1'b0, 1'b0, 4'd0, 64'hC1); push(2, 1'b0, 1'b1, 4'd8, 64'hC2);
    drive();
    run(10);
    check("two_msg_count", 64'(out_log.size()), 64'd6);
    exp_beat("two", 0, 2, 0, 1'b1, 1'b0, 4'd0, 64'hA0);
    exp_beat("two", 1, 3, 0, 1'b0, 1'b0, 4'd0, 64'hA1);
    exp_beat("two", 2, 4, 0, 1'b0, 1'b1, 4'd8, 64'hA2);
    exp_beat("two", 3, 6, 2, 1'b1, 1'b0, 4'd0, 64'hC0);
    exp_beat("two", 4, 7, 2, 1'b0, 1'b0, 4'd0, 64'hC1);
    exp_beat("two", 5, 8, 2, 1'b0, 1'b1, 4'd8, 64'hC2);
    check("two_err", 64'(err_count), 64'd0);

    // All four requesters offering single-beat messages: strict rotation
    reset_dut();
    begin_test();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NR; r++) push(r, 1'b1, 1'b1, 4'd8, 64'(r * 16 + rep));
    drive();
    run(18);
    check("rr_count", 64'(out_log.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      exp_beat("rr", k, 2 + 2 * k, k % 4, 1'b1, 1'b1, 4'd8, 64'((k % 4) * 16 + k / 4));
    check("rr_err", 64'(err_count), 64'd0);

    // Backpressure toggling during a 2-beat message from requester 1
    reset_dut();
    begin_test();
    for (int i = 0; i < 32; i++) ready_pat[i] = 1'b1;
    ready_pat[3] = 1'b0; ready_pat[5] = 1'b0;
    use_pat = 1'b1;
    push(1, 1'b1, 1'b0, 4'd0, 64'h11); push(1, 1'b0, 1'b1, 4'd5, 64'h22);
    drive();
    run(6);
    use_pat = 1'b0;
    check("bp_count", 64'(out_log.size()), 64'd2);
    exp_beat("bp", 0, 2, 1, 1'b1, 1'b0, 4'd0, 64'h11);
    exp_beat("bp", 1, 4, 1, 1'b0, 1'b1, 4'd5, 64'h22);
    check("bp_rdy_c2", 64'(rr_log[1]), 64'b0010);
    check("bp_rdy_c3", 64'(rr_log[2]), 64'b0000);
    check("bp_rdy_c4", 64'(rr_log[3]), 64'b0010);
    check("bp_src_left", 64'(rq[1].size()), 64'd0);

    // Stray beat in IDLE on requester 3
    reset_dut();
    begin_test();
    push(3, 1'b0, 1'b1, 4'd8, 64'h33);
    drive();
    run(4);
    check("stray_ready", 64'(rr_log[0]), 64'b1000);
    check("stray_out", 64'(out_log.size()), 64'd0);
    check("stray_err", 64'(err_count), 64'd1);
    check("stray_drained", 64'(rq[3].size()), 64'd0);

    // Stray beat alongside a Start beat
    reset_dut();
    begin_test();
    push(3, 1'b0, 1'b1, 4'd8, 64'h33);
    push(1, 1'b1, 1'b1, 4'd4, 64'h44);
    drive();
    run(5);
    check("mix_ready", 64'(rr_log[0]), 64'b1000);
    check("mix_err", 64'(err_count), 64'd1);
    check("mix_count", 64'(out_log.size()), 64'd1);
    exp_beat("mix", 0, 2, 1, 1'b1, 1'b1, 4'd4, 64'h44);

    // Mid-message Start and bad Mod on End are repaired and flagged
    reset_dut();
    begin_test();
    push(2, 1'b1, 1'b0, 4'd0, 64'h50); push(2, 1'b1, 1'b0, 4'd0, 64'h51); push(2, 1'b0, 1'b1, 4'd0, 64'h52);
    drive();
    run(6);
    check("fix_count", 64'(out_log.size()), 64'd3);
    exp_beat("fix", 0, 2, 2, 1'b1, 1'b0, 4'd0, 64'h50);
    exp_beat("fix", 1, 3, 2, 1'b0, 1'b0, 4'd0, 64'h51);
    exp_beat("fix", 2, 4, 2, 1'b0, 1'b1, 4'd8, 64'h52);
    check("fix_err", 64'(err_count), 64'd2);

    // Reset mid-message: outputs cleared, arbitration pointer restored
    reset_dut();
    begin_test();
    push(0, 1'b1, 1'b1, 4'd8, 64'h60);
    push(1, 1'b1, 1'b0, 4'd0, 64'h70); push(1, 1'b0, 1'b0, 4'd0, 64'h71); push(1, 1'b0, 1'b1, 4'd8, 64'h72);
    drive();
    run(4);
    check("mid_pre_count", 64'(out_log.size()), 64'd2);
    Rst = 1'b0;
    #1;
    check("mid_valid", 64'(OutBus_Valid), 64'h0);
    check("mid_ready", 64'(Req_Ready), 64'h0);
    check("mid_gid", 64'(Grant_Id), 64'h0);
    check("mid_end", 64'(OutBus_End_Msg), 64'h0);
    check("mid_data", OutBus_Data, 64'h0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive();
    run(1);
    Rst = 1'b1;
    begin_test();
    push(0, 1'b1, 1'b1, 4'd8, 64'h80);
    push(1, 1'b1, 1'b1, 4'd8, 64'h81);
    drive();
    run(5);
    check("post_count", 64'(out_log.size()), 64'd2);
    exp_beat("post", 0, 2, 0, 1'b1, 1'b1, 4'd8, 64'h80);
    exp_beat("post", 1, 4, 1, 1'b1, 1'b1, 4'd8, 64'h81);

`ifdef MSG_ARB_WATCHDOG_EN
    // Requester 0 goes silent after its Start beat; abort beat after 4 idle cycles
    reset_dut();
    begin_test();
    push(0, 1'b1, 1'b0, 4'd0, 64'h90);
    drive();
    run(9);
    check("wd_count", 64'(out_log.size()), 64'd2);
    exp_beat("wd", 0, 2, 0, 1'b1, 1'b0, 4'd0, 64'h90);
    exp_beat("wd", 1, 7, 0, 1'b0, 1'b1, 4'd0, 64'h0);
    check("wd_err", 64'(err_count), 64'd1);
    begin_test();
    push(0, 1'b0, 1'b1, 4'd8, 64'h91);
    drive();
    run(3);
    check("wd_stray_ready", 64'(rr_log[0]), 64'b0001);
    check("wd_stray_out", 64'(out_log.size()), 64'd0);
    check("wd_stray_err", 64'(err_count), 64'd1);
    begin_test();
    push(0, 1'b1, 1'b1, 4'd8, 64'h92);
    push(1, 1'b1, 1'b1, 4'd8, 64'h93);
    drive();
    run(3);
    exp_beat("wd_next", 0, 2, 1, 1'b1, 1'b1, 4'd8, 64'h93);
`endif

    dv[0] = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run expected completion");
    $fatal(1);
  end

endmodule

// File: doc/msg_arbiter.md
MSG_ARBITER -- requirements
Module: msg_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL be the data width in bits per requester beat and output beat.
REQ-002 Parameter NUM_REQ, default 4, SHALL be the number of requester streams (2..8).
REQ-003 Parameter WDOG_LIMIT, default 256, SHALL be the watchdog stall threshold in cycles (used only when the watchdog is compiled in).
REQ-004 Port Clk, input, 1 bit, SHALL be the single clock; all state is rising-edge.
REQ-005 Port Rst, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port Req_Valid, input, NUM_REQ bits, SHALL carry the per-requester beat-valid flag.
REQ-007 Port Req_Start, input, NUM_REQ bits, SHALL mark the first beat of a message.
REQ-008 Port Req_End, input, NUM_REQ bits, SHALL mark the last beat of a message.
REQ-009 Port Req_Mod, input, NUM_REQ*4 bits, SHALL carry the valid byte count 1..8 on End beats.
REQ-010 Port Req_Data, input, NUM_REQ*DATA_WIDTH bits, SHALL carry the flattened beat data, requester i at slice i.
REQ-011 Port Req_Ready, output, NUM_REQ bits, SHALL signal beat accepted.
REQ-012 Port OutBus_Ready, input, 1 bit, SHALL carry downstream backpressure.
REQ-013 Port OutBus_Valid, output, 1 bit, SHALL signal a valid output beat.
REQ-014 Ports OutBus_Sart_Msg and OutBus_End_Msg, outputs, 1 bit each, SHALL carry the message delimiters.
REQ-015 Port OutBus_Mod, output, 4 bits, SHALL carry the valid byte count of the output beat.
REQ-016 Port OutBus_Data, output, DATA_WIDTH bits, SHALL carry the output beat data.
REQ-017 Port Grant_Id, output, 3 bits, SHALL identify the current or last granted requester.
REQ-018 Port Err, output, 1 bit, SHALL pulse for one cycle per protocol error.

Function
REQ-019 A beat SHALL transfer on a requester i when Req_Valid[i] and Req_Ready[i] are both high.
REQ-020 The output SHALL transfer a beat when OutBus_Valid and OutBus_Ready are both high.
REQ-021 The FSM SHALL have states IDLE and BUSY; the ABORT state SHALL exist only when the watchdog is compiled in.
REQ-022 In IDLE, the arbiter SHALL select the first requester with Req_Valid=1 and Req_Start=1, searching round-robin from last_grant+1 modulo NUM_REQ.
REQ-023 The selection SHALL register Grant_Id and move to BUSY, giving 1 cycle of arbitration latency, with no beat consumed in that cycle.
REQ-024 In BUSY, OutBus_Valid, Sart_Msg, End_Msg, Mod and Data SHALL be combinational copies of the granted requester's signals.
REQ-025 In BUSY, Req_Ready[grant] SHALL equal OutBus_Ready, and all other Req_Ready bits SHALL be 0.
REQ-026 A transfer with End_Msg=1 in BUSY SHALL update last_grant to the grant and return to IDLE, so the message is never interleaved.
REQ-027 A message whose first beat has Start=1 and End=1 (single beat) SHALL be legal and return to IDLE after that one transfer.
REQ-028 In IDLE, a beat with Req_Valid=1 and Req_Start=0 (stray beat) SHALL be drained with Req_Ready=1 and discarded, and SHALL pulse Err.
REQ-029 In BUSY, a granted beat with Start=1 SHALL be forwarded with Sart_Msg forced to 0 and SHALL pulse Err.
REQ-030 In BUSY, a beat with End=1 and Mod of 0 or greater than 8 SHALL be forwarded with Mod forced to 8 and SHALL pulse Err.
REQ-031 In IDLE, OutBus_Valid SHALL be 0 and all other outputs except Grant_Id SHALL be 0.
REQ-032 Simultaneous stray and Start beats in IDLE SHALL drain the stray beats, arbitrate the Start beats, and pulse Err once.

Reset
REQ-033 While Rst=0, the FSM SHALL be forced to IDLE, last_grant to NUM_REQ-1 (so requester 0 wins first), Grant_Id to 0, Err to 0 and the watchdog counter to 0.
REQ-034 While Rst=0, all outputs SHALL be 0.
REQ-035 Reset asserted mid-message SHALL abandon the message with no End beat emitted.

Configuration
REQ-036 With macro MSG_ARB_WATCHDOG_EN defined, a counter SHALL count BUSY cycles in which Req_Valid[grant]=0, clearing on any granted beat.
REQ-037 When that counter reaches WDOG_LIMIT, the FSM SHALL enter ABORT.
REQ-038 In ABORT, the block SHALL drive OutBus_Valid=1, End_Msg=1, Mod=0 and Data=0 until OutBus_Ready=1, then pulse Err and return to IDLE with last_grant set to the grant.
REQ-039 After an abort, later beats from that requester SHALL be treated as stray beats.
REQ-040 Without MSG_ARB_WATCHDOG_EN, no counter SHALL exist and BUSY SHALL wait indefinitely.

Verification
REQ-041 Requesters 0 and 2 each present a 3-beat message at the same time, OutBus_Ready=1 -> 0's beats on cycles 2-4, IDLE on cycle 5, 2's beats on cycles 6-8, Grant_Id 0 then 2.
REQ-042 All 4 requesters continuously offer single-beat messages -> grants follow the order 0,1,2,3,0, each requester served once per 4 messages.
REQ-043 OutBus_Ready toggles 1,0,1,0 during a 2-beat message from requester 1 -> Req_Ready[1] mirrors OutBus_Ready, no beat is lost or duplicated, and End_Msg comes out with Mod=5.
REQ-044 Stray beat (Start=0) on requester 3 while IDLE -> Req_Ready[3]=1, no output beat, Err pulses once.
REQ-045 Reset pulled low in the middle of a message, then released -> all outputs 0, IDLE, and the next grant goes to requester 0.
REQ-046 With MSG_ARB_WATCHDOG_EN and WDOG_LIMIT=4, the granted requester goes silent after its Start beat -> after 4 cycles an abort beat (End=1, Mod=0, Data=0) is emitted, Err pulses, and the FSM returns to IDLE.
